bank_cmd_scheduler: RTL and testbench

BANK_CMD_SCHEDULER -- requirements
Module: bank_cmd_scheduler

---
 rtl/bank_cmd_scheduler_pkg.sv | 31 +++
 rtl/bank_cmd_scheduler_rr_arbiter.sv | 33 +++
 rtl/bank_cmd_scheduler.sv | 170 +++++++++++++++++
 tb/tb_bank_cmd_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_cmd_scheduler_pkg.sv
// Shared types and constants for the bank command scheduler: command codes,
// per-bank counter state encodings, refresh timing and the scheduler FSM enum.
package bank_cmd_scheduler_pkg;

  localparam int BA_BITS    = 3;
  localparam int FSM_WIDTH1 = 4;
  localparam int CYCLE_TRFC = 12;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } cmd_e;

  localparam logic [FSM_WIDTH1-1:0] FSM_IDLE    = 4'd0;
  localparam logic [FSM_WIDTH1-1:0] FSM_ACTIVE  = 4'd1;
  localparam logic [FSM_WIDTH1-1:0] FSM_READ    = 4'd2;
  localparam logic [FSM_WIDTH1-1:0] FSM_WRITE   = 4'd3;
  localparam logic [FSM_WIDTH1-1:0] FSM_PRE     = 4'd4;
  localparam logic [FSM_WIDTH1-1:0] FSM_REFRESH = 4'd5;

  typedef enum logic [2:0] {
    S_SCHED    = 3'd0,
    S_REF_PREA = 3'd1,
    S_REF_TRP  = 3'd2,
    S_REF_CMD  = 3'd3,
    S_REF_WAIT = 3'd4
  } sched_state_e;

endpackage

// File: rtl/bank_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] idx,
  output logic            valid
);

  int  cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = IDXW'(cand);
        found       = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/bank_cmd_scheduler.sv
// Per-bank command scheduler: round-robin grant of ACT/RD/WR/PRE requests,
// bank open tracking, and the precharge-all / refresh / tRFC wait sequence.
module bank_cmd_scheduler
  import bank_cmd_scheduler_pkg::*;
#(
  parameter int NBANK = 2**BA_BITS,
  parameter int TRFC  = CYCLE_TRFC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NBANK-1:0]            req_valid,
  input  logic [NBANK-1:0][1:0]       req_cmd,
  input  logic [NBANK-1:0]            req_ap,
  input  logic [NBANK-1:0]            tP_zero,
  input  logic [NBANK-1:0]            tRAS_zero,
  input  logic                        ref_req,
  output logic [NBANK-1:0]            req_ack,
  output logic [FSM_WIDTH1-1:0]       state_nxt,
  output logic [BA_BITS-1:0]          f_bank,
  output logic                        auto_pre,
  output logic                        refresh_flag,
  output logic                        ref_ack,
  output logic [NBANK-1:0]            bank_open
);

  sched_state_e              state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [NBANK-1:0]          busy_q, busy_d;
  logic [NBANK-1:0]          bank_open_q, bank_open_d;
  logic [BA_BITS-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NBANK-1:0]          req_ack_q, req_ack_d;
  logic [FSM_WIDTH1-1:0]     state_nxt_q, state_nxt_d;
  logic [BA_BITS-1:0]        f_bank_q, f_bank_d;
  logic                      auto_pre_q, auto_pre_d;
  logic                      refresh_flag_q, refresh_flag_d;
  logic                      ref_ack_q, ref_ack_d;

  logic [NBANK-1:0]          eligible;
  logic [NBANK-1:0]          gnt;
  logic [BA_BITS-1:0]        gnt_idx;
  logic                      gnt_valid;

  // A bank granted last cycle is masked so no bank is issued twice in a row.
  always_comb begin
    eligible = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (req_valid[b] && tP_zero[b] && !busy_q[b]) begin
        case (cmd_e'(req_cmd[b]))
          CMD_ACT:        eligible[b] = !bank_open_q[b];
          CMD_RD, CMD_WR: eligible[b] = bank_open_q[b];
          default:        eligible[b] = bank_open_q[b] && tRAS_zero[b];
        endcase
      end
    end
  end

  rr_arbiter #(.N(NBANK), .IDXW(BA_BITS)) u_rr_arbiter (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .grant (gnt),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    busy_d         = '0;
    bank_open_d    = bank_open_q;
    rr_ptr_d       = rr_ptr_q;
    req_ack_d      = '0;
    state_nxt_d    = FSM_IDLE;
    f_bank_d       = f_bank_q;
    auto_pre_d     = 1'b0;
    refresh_flag_d = 1'b0;
    ref_ack_d      = 1'b0;
    case (state_q)
      S_SCHED: begin
        if (ref_req) begin
          state_d = (|bank_open_q) ? S_REF_PREA : S_REF_TRP;
        end else if (gnt_valid) begin
          req_ack_d = gnt;
          busy_d    = gnt;
          f_bank_d  = gnt_idx;
          rr_ptr_d  = (gnt_idx == BA_BITS'(NBANK - 1)) ? '0 : gnt_idx + 1'b1;
          case (cmd_e'(req_cmd[gnt_idx]))
            CMD_ACT: begin
              state_nxt_d          = FSM_ACTIVE;
              bank_open_d[gnt_idx] = 1'b1;
            end
            CMD_RD, CMD_WR: begin
              state_nxt_d = (cmd_e'(req_cmd[gnt_idx]) == CMD_RD) ? FSM_READ : FSM_WRITE;
              auto_pre_d  = req_ap[gnt_idx];
              if (req_ap[gnt_idx]) bank_open_d[gnt_idx] = 1'b0;
            end
            default: begin
              state_nxt_d          = FSM_PRE;
              bank_open_d[gnt_idx] = 1'b0;
            end
          endcase
        end
      end
      S_REF_PREA: begin
        if (&(~bank_open_q | (tP_zero & tRAS_zero))) begin
          state_nxt_d    = FSM_PRE;
          refresh_flag_d = 1'b1;
          f_bank_d       = '0;
          bank_open_d    = '0;
          busy_d         = '1;
          state_d        = S_REF_TRP;
        end
      end
      S_REF_TRP: begin
        if (busy_q == '0 && &tP_zero) state_d = S_REF_CMD;
      end
      S_REF_CMD: begin
        state_nxt_d    = FSM_REFRESH;
        refresh_flag_d = 1'b1;
        cnt_d          = 8'(TRFC - 1);
        state_d        = S_REF_WAIT;
      end
      S_REF_WAIT: begin
        if (cnt_q == 8'd0) begin
          ref_ack_d = 1'b1;
          state_d   = S_SCHED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_SCHED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_SCHED;
      cnt_q          <= '0;
      busy_q         <= '0;
      bank_open_q    <= '0;
      rr_ptr_q       <= '0;
      req_ack_q      <= '0;
      state_nxt_q    <= FSM_IDLE;
      f_bank_q       <= '0;
      auto_pre_q     <= 1'b0;
      refresh_flag_q <= 1'b0;
      ref_ack_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      bank_open_q    <= bank_open_d;
      rr_ptr_q       <= rr_ptr_d;
      req_ack_q      <= req_ack_d;
      state_nxt_q    <= state_nxt_d;
      f_bank_q       <= f_bank_d;
      auto_pre_q     <= auto_pre_d;
      refresh_flag_q <= refresh_flag_d;
      ref_ack_q      <= ref_ack_d;
    end
  end

  assign req_ack      = req_ack_q;
  assign state_nxt    = state_nxt_q;
  assign f_bank       = f_bank_q;
  assign auto_pre     = auto_pre_q;
  assign refresh_flag = refresh_flag_q;
  assign ref_ack      = ref_ack_q;
  assign bank_open    = bank_open_q;

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// Self-checking bench for bank_cmd_scheduler: directed scenarios plus a
// randomized run against a behavioural arbitration model.
module tb_bank_cmd_scheduler;
  import bank_cmd_scheduler_pkg::*;

  localparam int NB = 8;
  localparam int TR = CYCLE_TRFC;
  localparam logic [1:0] C_ACT = 2'd0, C_RD = 2'd1, C_WR = 2'd2, C_PRE = 2'd3;

  logic                  clk;
  logic                  rst_n;
  logic [NB-1:0]         req_valid;
  logic [NB-1:0][1:0]    req_cmd;
  logic [NB-1:0]         req_ap;
  logic [NB-1:0]         tP_zero;
  logic [NB-1:0]         tRAS_zero;
  logic                  ref_req;
  logic [NB-1:0]         req_ack;
  logic [FSM_WIDTH1-1:0] state_nxt;
  logic [BA_BITS-1:0]    f_bank;
  logic                  auto_pre;
  logic                  refresh_flag;
  logic                  ref_ack;
  logic [NB-1:0]         bank_open;

  int vecs = 0;
  int errs = 0;

  bank_cmd_scheduler #(.NBANK(NB), .TRFC(TR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_ap       (req_ap),
    .tP_zero      (tP_zero),
    .tRAS_zero    (tRAS_zero),
    .ref_req      (ref_req),
    .req_ack      (req_ack),
    .state_nxt    (state_nxt),
    .f_bank       (f_bank),
    .auto_pre     (auto_pre),
    .refresh_flag (refresh_flag),
    .ref_ack      (ref_ack),
    .bank_open    (bank_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_cmd   = '0;
    req_ap    = '0;
    tP_zero   = '1;
    tRAS_zero = '1;
    ref_req   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vecs++;
    if ({req_ack, state_nxt, f_bank, auto_pre, refresh_flag, ref_ack, bank_open} !==
        {8'h00, FSM_IDLE, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errs++;
      $display("[TB] FAIL reset_values: ack=%h st=%0d fb=%0d ap=%b rf=%b ra=%b open=%h, want all zero/IDLE",
               req_ack, state_nxt, f_bank, auto_pre, refresh_flag, ref_ack, bank_open);
    end
  endtask

  task automatic test_act();
    do_reset();
    req_valid = 8'h04;
    req_cmd[2] = C_ACT;
    tick();
    req_valid = '0;
    vecs++;
    if ({state_nxt, f_bank, req_ack, bank_open} !== {FSM_ACTIVE, 3'd2, 8'h04, 8'h04}) begin
      errs++;
      $display("[TB] FAIL act_bank2: st=%0d fb=%0d ack=%h open=%h, want st=%0d fb=2 ack=04 open=04",
               state_nxt, f_bank, req_ack, bank_open, FSM_ACTIVE);
    end
    tick();
    vecs++;
    if ({state_nxt, req_ack} !== {FSM_IDLE, 8'h00}) begin
      errs++;
      $display("[TB] FAIL act_idle_after: st=%0d ack=%h, want IDLE ack=00", state_nxt, req_ack);
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [4] = '{1, 3, 6, 1};
    int open_seq [3] = '{1, 3, 6};
    int prev;
    do_reset();
    req_valid = 8'h4A;
    for (int b = 0; b < NB; b++) req_cmd[b] = C_ACT;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (req_ack !== (8'h01 << open_seq[i]) || state_nxt !== FSM_ACTIVE) begin
        errs++;
        $display("[TB] FAIL rr_act_%0d: ack=%h st=%0d, want ack=%h st=%0d",
                 i, req_ack, state_nxt, 8'h01 << open_seq[i], FSM_ACTIVE);
      end
    end
    for (int b = 0; b < NB; b++) req_cmd[b] = C_RD;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++;
      if (req_ack !== (8'h01 << exp_seq[i]) || int'(f_bank) !== exp_seq[i] ||
          state_nxt !== FSM_READ || int'(f_bank) == prev) begin
        errs++;
        $display("[TB] FAIL rr_read_%0d: ack=%h fb=%0d st=%0d, want ack=%h fb=%0d st=%0d",
                 i, req_ack, f_bank, state_nxt, 8'h01 << exp_seq[i], exp_seq[i], FSM_READ);
      end
      prev = int'(f_bank);
    end
    req_valid = '0;
  endtask

  task automatic test_pre_tras();
    do_reset();
    req_valid = 8'h20;
    req_cmd[5] = C_ACT;
    tick();
    req_cmd[5] = C_PRE;
    tRAS_zero[5] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++;
      if (req_ack !== 8'h00 || state_nxt !== FSM_IDLE) begin
        errs++;
        $display("[TB] FAIL pre_tras_hold_%0d: ack=%h st=%0d, want ack=00 IDLE", i, req_ack, state_nxt);
      end
    end
    tRAS_zero[5] = 1'b1;
    tick();
    req_valid = '0;
    vecs++;
    if ({state_nxt, f_bank, req_ack, bank_open[5]} !== {FSM_PRE, 3'd5, 8'h20, 1'b0}) begin
      errs++;
      $display("[TB] FAIL pre_bank5: st=%0d fb=%0d ack=%h open5=%b, want st=%0d fb=5 ack=20 open5=0",
               state_nxt, f_bank, req_ack, bank_open[5], FSM_PRE);
    end
  endtask

  task automatic test_wr_autopre();
    do_reset();
    req_valid = 8'h01;
    req_cmd[0] = C_ACT;
    tick();
    req_cmd[0] = C_WR;
    req_ap[0] = 1'b1;
    tick();
    vecs++;
    if (req_ack !== 8'h00) begin
      errs++;
      $display("[TB] FAIL wr_busy_mask: ack=%h, want 00", req_ack);
    end
    tick();
    req_valid = '0;
    vecs++;
    if ({state_nxt, auto_pre, req_ack, bank_open[0]} !== {FSM_WRITE, 1'b1, 8'h01, 1'b0}) begin
      errs++;
      $display("[TB] FAIL wr_autopre: st=%0d ap=%b ack=%h open0=%b, want st=%0d ap=1 ack=01 open0=0",
               state_nxt, auto_pre, req_ack, bank_open[0], FSM_WRITE);
    end
    req_ap = '0;
  endtask

  task automatic test_refresh();
    bit seen;
    int cycles;
    do_reset();
    req_valid = 8'h11;
    req_cmd[0] = C_ACT;
    req_cmd[4] = C_ACT;
    tick();
    tick();
    vecs++;
    if (bank_open !== 8'h11) begin
      errs++;
      $display("[TB] FAIL ref_setup_open: open=%h, want 11", bank_open);
    end
    req_valid = 8'h10;
    req_cmd[4] = C_RD;
    ref_req = 1'b1;
    tick();
    ref_req = 1'b0;
    vecs++;
    if (req_ack !== 8'h00 || state_nxt !== FSM_IDLE) begin
      errs++;
      $display("[TB] FAIL ref_entry_no_grant: ack=%h st=%0d, want ack=00 IDLE", req_ack, state_nxt);
    end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (state_nxt == FSM_PRE) seen = 1;
      else tick();
    end
    vecs++;
    if (!seen || refresh_flag !== 1'b1 || f_bank !== 3'd0 || bank_open !== 8'h00 || req_ack !== 8'h00) begin
      errs++;
      $display("[TB] FAIL ref_prea: seen=%0d rf=%b fb=%0d open=%h ack=%h, want seen=1 rf=1 fb=0 open=00 ack=00",
               seen, refresh_flag, f_bank, bank_open, req_ack);
    end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (req_ack !== 8'h00) begin
        vecs++;
        errs++;
        $display("[TB] FAIL ref_ack_during_seq: ack=%h, want 00", req_ack);
      end
      if (state_nxt == FSM_REFRESH) seen = 1;
    end
    vecs++;
    if (!seen || refresh_flag !== 1'b1) begin
      errs++;
      $display("[TB] FAIL ref_cmd: seen=%0d rf=%b, want seen=1 rf=1", seen, refresh_flag);
    end
    cycles = 0;
    seen = 0;
    for (int i = 0; i < TR + 10 && !seen; i++) begin
      tick();
      cycles++;
      if (ref_ack === 1'b1) seen = 1;
    end
    vecs++;
    if (!seen || cycles != TR) begin
      errs++;
      $display("[TB] FAIL ref_ack_latency: seen=%0d cycles=%0d, want seen=1 cycles=%0d", seen, cycles, TR);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vecs++;
      if (req_ack !== 8'h00 || ref_ack !== 1'b0) begin
        errs++;
        $display("[TB] FAIL ref_rd_rejected_%0d: ack=%h ref_ack=%b, want 00 and 0", i, req_ack, ref_ack);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_refresh();
    bit seen;
    do_reset();
    ref_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      ref_req = 1'b0;
      if (state_nxt == FSM_REFRESH) seen = 1;
    end
    vecs++;
    if (!seen) begin
      errs++;
      $display("[TB] FAIL midref_reach_wait: seen=%0d, want 1", seen);
    end
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({req_ack, state_nxt, f_bank, auto_pre, refresh_flag, ref_ack, bank_open} !==
        {8'h00, FSM_IDLE, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errs++;
      $display("[TB] FAIL midref_async_reset: ack=%h st=%0d rf=%b ra=%b, want zero/IDLE",
               req_ack, state_nxt, refresh_flag, ref_ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < TR + 4; i++) begin
      tick();
      vecs++;
      if (ref_ack !== 1'b0 || state_nxt !== FSM_IDLE || refresh_flag !== 1'b0) begin
        errs++;
        $display("[TB] FAIL midref_no_pulse_%0d: ra=%b st=%0d rf=%b, want 0 IDLE 0",
                 i, ref_ack, state_nxt, refresh_flag);
      end
    end
  endtask

  task automatic test_random();
    bit   open_m [NB];
    int   ptr_m;
    int   last_m;
    int   g;
    logic [1:0] c;
    logic [NB-1:0] exp_ack;
    logic [FSM_WIDTH1-1:0] exp_st;
    logic exp_ap;
    logic [NB-1:0] exp_open;
    do_reset();
    for (int b = 0; b < NB; b++) open_m[b] = 0;
    ptr_m = 0;
    last_m = -1;
    for (int n = 0; n < 400; n++) begin
      req_valid = NB'($urandom);
      for (int b = 0; b < NB; b++) begin
        req_cmd[b]   = 2'($urandom);
        req_ap[b]    = ($urandom_range(3) == 0);
        tP_zero[b]   = ($urandom_range(3) != 0);
        tRAS_zero[b] = ($urandom_range(3) != 0);
      end
      g = -1;
      for (int k = 0; k < NB && g < 0; k++) begin
        int b;
        bit ok;
        b = (ptr_m + k) % NB;
        c = req_cmd[b];
        ok = req_valid[b] && tP_zero[b] && (b != last_m);
        if (c == C_ACT) ok = ok && !open_m[b];
        else if (c == C_PRE) ok = ok && open_m[b] && tRAS_zero[b];
        else ok = ok && open_m[b];
        if (ok) g = b;
      end
      exp_ack = '0;
      exp_st  = FSM_IDLE;
      exp_ap  = 1'b0;
      if (g >= 0) begin
        c = req_cmd[g];
        exp_ack[g] = 1'b1;
        if (c == C_ACT) begin
          exp_st = FSM_ACTIVE;
          open_m[g] = 1;
        end else if (c == C_PRE) begin
          exp_st = FSM_PRE;
          open_m[g] = 0;
        end else begin
          exp_st = (c == C_RD) ? FSM_READ : FSM_WRITE;
          exp_ap = req_ap[g];
          if (req_ap[g]) open_m[g] = 0;
        end
        ptr_m = (g + 1) % NB;
      end
      last_m = g;
      for (int b = 0; b < NB; b++) exp_open[b] = open_m[b];
      tick();
      vecs++;
      if (req_ack !== exp_ack || state_nxt !== exp_st || auto_pre !== exp_ap ||
          bank_open !== exp_open || (g >= 0 && int'(f_bank) !== g)) begin
        errs++;
        $display("[TB] FAIL random_%0d: ack=%h st=%0d ap=%b open=%h fb=%0d, want ack=%h st=%0d ap=%b open=%h fb=%0d",
                 n, req_ack, state_nxt, auto_pre, bank_open, f_bank, exp_ack, exp_st, exp_ap, exp_open, g);
      end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_act();
    test_round_robin();
    test_pre_tras();
    test_wr_autopre();
    test_refresh();
    test_reset_mid_refresh();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
